// File: rtl/puf_crp_verifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | puf_crp_verifier                                                         |
// | Drives a ring-oscillator PUF through REPEATS evaluations, majority-votes |
// | the response and compares it against an enrolled reference.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module puf_crp_verifier #(
  parameter int CHAL_W        = 4,
  parameter int RESP_W        = 4,
  parameter int SETTLE_CYCLES = 1024,
  parameter int GAP_CYCLES    = 16,
  parameter int REPEATS       = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] cha0_in,
  input  logic [CHAL_W-1:0] cha1_in,
  input  logic [RESP_W-1:0] expected_resp,
  output logic [CHAL_W-1:0] puf_cha0,
  output logic [CHAL_W-1:0] puf_cha1,
  output logic              puf_enable,
  input  logic [RESP_W-1:0] puf_response,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] voted_resp,
  output logic [RESP_W-1:0] unstable
);

  localparam int c_VW   = $clog2(REPEATS + 1);
  localparam int c_MAXC = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
  localparam int c_CW   = $clog2(c_MAXC + 1);

  localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(GAP_CYCLES - 1);
  localparam logic [c_CW-1:0] c_RUN_LAST  = c_CW'(SETTLE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_SYNC_LAST = c_CW'(1);
  localparam logic [c_VW-1:0] c_REPS      = c_VW'(REPEATS);
  localparam logic [c_VW-1:0] c_HALF      = c_VW'(REPEATS / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GAP    = 3'd2,
    S_RUN    = 3'd3,
    S_SYNC   = 3'd4,
    S_DECIDE = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_CW-1:0]   r_cnt;
  logic [c_VW-1:0]   r_rep;
  logic [c_VW-1:0]   w_rep_inc;
  logic              w_accept;
  logic              w_abort;
  logic              w_vote_en;
  logic              w_decide;
  logic [CHAL_W-1:0] r_cha0;
  logic [CHAL_W-1:0] r_cha1;
  logic [RESP_W-1:0] r_expected;
  logic [RESP_W-1:0] r_resp_meta;
  logic [RESP_W-1:0] r_resp_sync;
  logic [RESP_W-1:0] w_voted;
  logic [RESP_W-1:0] w_unstable;
  logic              r_done;
  logic              r_pass;
  logic [RESP_W-1:0] r_voted;
  logic [RESP_W-1:0] r_unstable;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_vote_en = 1'b0;
    w_decide  = 1'b0;
    w_rep_inc = r_rep + 1'b1;
    w_abort   = abort && (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (start) begin
        w_accept = 1'b1;
        w_next   = S_LOAD;
      end
      S_LOAD: w_next = S_GAP;
      S_GAP:  if (r_cnt == c_GAP_LAST) w_next = S_RUN;
      S_RUN:  if (r_cnt == c_RUN_LAST) w_next = S_SYNC;
      S_SYNC: if (r_cnt == c_SYNC_LAST) begin
        w_vote_en = 1'b1;
        w_next    = (w_rep_inc == c_REPS) ? S_DECIDE : S_GAP;
      end
      S_DECIDE: begin
        w_decide = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides whatever transition the state would otherwise take.
    if (w_abort) begin
      w_next    = S_IDLE;
      w_vote_en = 1'b0;
      w_decide  = 1'b0;
    end
  end

  // Per-state cycle counter restarts on every state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                r_cnt <= '0;
    else if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
    else                                         r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rep      <= '0;
      r_cha0     <= '0;
      r_cha1     <= '0;
      r_expected <= '0;
    end else if (w_accept) begin
      r_rep      <= '0;
      r_cha0     <= cha0_in;
      r_cha1     <= cha1_in;
      r_expected <= expected_resp;
    end else if (w_vote_en) begin
      r_rep      <= w_rep_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_meta <= '0;
      r_resp_sync <= '0;
    end else begin
      r_resp_meta <= puf_response;
      r_resp_sync <= r_resp_meta;
    end
  end

  generate
    for (genvar i = 0; i < RESP_W; i++) begin : g_bit
      logic [c_VW-1:0] r_vote;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       r_vote <= '0;
        else if (w_accept)  r_vote <= '0;
        else if (w_vote_en) r_vote <= r_vote + c_VW'(r_resp_sync[i]);
      end
      assign w_voted[i]    = (r_vote > c_HALF);
      assign w_unstable[i] = (r_vote != '0) && (r_vote != c_REPS);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_voted    <= '0;
      r_unstable <= '0;
    end else begin
      r_done <= w_decide;
      if (w_accept || w_abort) begin
        r_pass     <= 1'b0;
        r_voted    <= '0;
        r_unstable <= '0;
      end else if (w_decide) begin
        r_pass     <= (w_voted == r_expected);
        r_voted    <= w_voted;
        r_unstable <= w_unstable;
      end
    end
  end

  assign puf_cha0   = r_cha0;
  assign puf_cha1   = r_cha1;
  assign puf_enable = (r_state == S_RUN) || (r_state == S_SYNC);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign pass       = r_pass;
  assign voted_resp = r_voted;
  assign unstable   = r_unstable;

endmodule
`default_nettype wire

// File: tb/tb_puf_crp_verifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_puf_crp_verifier                                                      |
// | Randomized self-checking bench with a per-evaluation PUF response model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_puf_crp_verifier;

  localparam int CW  = 4;
  localparam int RW  = 4;
  localparam int SET = 20;
  localparam int GAP = 4;
  localparam int REP = 3;
  localparam int LAT = 2 + REP * (GAP + SET + 2);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cha0_in = '0;
  logic [CW-1:0] cha1_in = '0;
  logic [RW-1:0] expected_resp = '0;
  logic [RW-1:0] puf_response = '0;
  logic [CW-1:0] puf_cha0;
  logic [CW-1:0] puf_cha1;
  logic          puf_enable;
  logic          busy;
  logic          done;
  logic          pass;
  logic [RW-1:0] voted_resp;
  logic [RW-1:0] unstable;

  puf_crp_verifier #(
    .CHAL_W(CW), .RESP_W(RW), .SETTLE_CYCLES(SET), .GAP_CYCLES(GAP), .REPEATS(REP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cha0_in(cha0_in), .cha1_in(cha1_in), .expected_resp(expected_resp),
    .puf_cha0(puf_cha0), .puf_cha1(puf_cha1), .puf_enable(puf_enable),
    .puf_response(puf_response), .busy(busy), .done(done), .pass(pass),
    .voted_resp(voted_resp), .unstable(unstable)
  );

  always #5 clock = ~clock;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [RW-1:0] resp_seq [REP];
  int            eval_idx = 0;

  // PUF model: each enable pulse is one evaluation returning the next table entry.
  always @(posedge puf_enable) begin
    if (eval_idx < REP) puf_response = resp_seq[eval_idx];
    eval_idx++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic [RW-1:0] ex, output logic [RW-1:0] v,
                                output logic [RW-1:0] u, output logic p);
    for (int b = 0; b < RW; b++) begin
      int ones = 0;
      for (int r = 0; r < REP; r++) ones += int'(resp_seq[r][b]);
      v[b] = (ones * 2 > REP);
      u[b] = (ones != 0) && (ones != REP);
    end
    p = (v == ex);
  endfunction

  task automatic start_req(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                           input logic [RW-1:0] ex);
    start = 1'b1;
    cha0_in = c0;
    cha1_in = c1;
    expected_resp = ex;
    eval_idx = 0;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int poke_at,
                           input logic [CW-1:0] c0, input logic [CW-1:0] c1);
    int cyc = 0;
    int busy_low = 0;
    while (done !== 1'b1 && cyc < LAT + 50) begin
      if (cyc == poke_at) begin
        start = 1'b1;
        cha0_in = ~c0;
        cha1_in = ~c1;
        expected_resp = ~expected_resp;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) busy_low++;
      if (cyc == poke_at + 1) begin
        check({tag, "_ign_cha0"}, puf_cha0, c0);
        check({tag, "_ign_cha1"}, puf_cha1, c1);
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_busy_held"}, busy_low, 0);
  endtask

  task automatic check_result(input string tag, input logic [RW-1:0] ex, input bit follow);
    logic [RW-1:0] v, u;
    logic p;
    model(ex, v, u, p);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_voted"}, voted_resp, v);
    check({tag, "_unstable"}, unstable, u);
    check({tag, "_pass"}, pass, p);
    check({tag, "_evals"}, eval_idx, REP);
    if (follow) begin
      @(posedge clock); #1;
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_pass_hold"}, pass, p);
    end
  endtask

  initial begin
    logic [CW-1:0] c0, c1;
    logic [RW-1:0] ex, v, u, base;
    logic p;
    int seen;

    foreach (resp_seq[r]) resp_seq[r] = 4'hA;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_voted", voted_resp, '0);
    check("rst_enable", puf_enable, 1'b0);
    check("rst_cha0", puf_cha0, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Stable response matching the enrolled value.
    @(negedge clock);
    start_req(4'h3, 4'hC, 4'hA);
    check("t1_busy", busy, 1'b1);
    check("t1_cha0", puf_cha0, 4'h3);
    check("t1_cha1", puf_cha1, 4'hC);
    wait_done("t1", -5, 4'h3, 4'hC);
    check_result("t1", 4'hA, 1);
    check("t1_voted_a", voted_resp, 4'hA);

    // Same response, wrong enrolled value.
    @(negedge clock);
    start_req(4'h1, 4'h2, 4'h5);
    wait_done("t2", -5, 4'h1, 4'h2);
    check_result("t2", 4'h5, 1);
    check("t2_pass0", pass, 1'b0);

    // Flaky bit 0, plus a start pulse mid-RUN that must be ignored.
    resp_seq[0] = 4'hA; resp_seq[1] = 4'hB; resp_seq[2] = 4'hA;
    @(negedge clock);
    start_req(4'h7, 4'h9, 4'hA);
    wait_done("t3", 10, 4'h7, 4'h9);
    check_result("t3", 4'hA, 0);
    check("t3_unstable1", unstable, 4'h1);

    // Start accepted in the done cycle clears the held results.
    resp_seq[0] = 4'h6; resp_seq[1] = 4'h6; resp_seq[2] = 4'h6;
    start_req(4'h4, 4'h5, 4'h6);
    check("t4_busy", busy, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_pass_clr", pass, 1'b0);
    check("t4_voted_clr", voted_resp, '0);
    check("t4_unst_clr", unstable, '0);
    wait_done("t4", -5, 4'h4, 4'h5);
    check_result("t4", 4'h6, 1);

    // Abort during the second RUN.
    @(negedge clock);
    start_req(4'h2, 4'h8, 4'h6);
    repeat (40) @(posedge clock);
    #1;
    check("ab_enable_before", puf_enable, 1'b1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("ab_enable", puf_enable, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_pass", pass, 1'b0);
    check("ab_voted", voted_resp, '0);
    check("ab_evals", eval_idx, 2);
    seen = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("ab_no_done", seen, 0);

    // Reset during RUN drops enable asynchronously.
    @(negedge clock);
    start_req(4'hF, 4'h0, 4'h6);
    repeat (10) @(posedge clock);
    #2;
    check("rr_enable_before", puf_enable, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rr_enable", puf_enable, 1'b0);
    check("rr_busy", busy, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_req(4'hE, 4'h1, 4'h6);
    wait_done("rr", -5, 4'hE, 4'h1);
    check_result("rr", 4'h6, 1);

    // Randomized requests with occasional flipped evaluations.
    for (int it = 0; it < 8; it++) begin
      c0 = CW'($urandom);
      c1 = CW'($urandom);
      base = RW'($urandom);
      for (int r = 0; r < REP; r++)
        resp_seq[r] = base ^ (($urandom_range(0, 2) == 0) ? RW'($urandom) : RW'(0));
      model(4'h0, v, u, p);
      ex = ($urandom_range(0, 1) == 1) ? v : RW'($urandom);
      @(negedge clock);
      start_req(c0, c1, ex);
      wait_done("rnd", -5, c0, c1);
      check_result("rnd", ex, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
